// File: rtl/gppcu_fpu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FPU among NTHREAD threads.
// One job in flight: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT timeout abort.
module gppcu_fpu_arbiter #(
  parameter int NTHREAD = 4,
  parameter int DBW     = 32,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   iACLK,
  input  logic                   iARESETn,
  input  logic [NTHREAD-1:0]     iREQ,
  input  logic [NTHREAD*DBW-1:0] iOPA,
  input  logic [NTHREAD*DBW-1:0] iOPB,
  input  logic [NTHREAD*OPW-1:0] iOPN,
  output logic [NTHREAD-1:0]     oBUSY,
  output logic [NTHREAD-1:0]     oDONE,
  output logic                   oERR,
  output logic [DBW-1:0]         oRESULT,
  output logic                   oFP_START,
  output logic [DBW-1:0]         oFP_DATAA,
  output logic [DBW-1:0]         oFP_DATAB,
  output logic [OPW-1:0]         oFP_N,
  input  logic                   iFP_DONE,
  input  logic [DBW-1:0]         iFP_RESULT
);

  localparam int GW = (NTHREAD > 1) ? $clog2(NTHREAD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [GW-1:0]  last_q;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  win;
  logic           any_req;
  logic           tmo;
  logic [7:0]     cnt_q;
  logic [DBW-1:0] opa_q;
  logic [DBW-1:0] opb_q;
  logic [DBW-1:0] res_q;
  logic [OPW-1:0] opn_q;
  logic           err_q;
  int             idx;

  assign any_req = |iREQ;
  assign tmo     = (cnt_q == 8'(TIMEOUT));

  // Round-robin pick: scan from farthest to nearest so the
  // first requester after last_q overwrites the others.
  always_comb begin
    win = last_q;
    idx = 0;
    for (int k = NTHREAD; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NTHREAD;
      if (iREQ[idx]) win = GW'(idx);
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (iFP_DONE || tmo) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Job latches, timeout counter and rotation pointer.
  always_ff @(posedge iACLK or negedge iARESETn) begin
    if (!iARESETn) begin
      last_q  <= GW'(NTHREAD - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opn_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= win;
            opa_q   <= iOPA[int'(win)*DBW +: DBW];
            opb_q   <= iOPB[int'(win)*DBW +: DBW];
            opn_q   <= iOPN[int'(win)*OPW +: OPW];
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (iFP_DONE) begin
            res_q <= iFP_RESULT;
            err_q <= 1'b0;
          end else if (tmo) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: last_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign oFP_START = (state_q == ISSUE);
  assign oDONE     = (state_q == RESP) ?
                     (NTHREAD'(1) << grant_q) : '0;
  assign oERR      = (state_q == RESP) && err_q;
  assign oRESULT   = res_q;
  assign oFP_DATAA = opa_q;
  assign oFP_DATAB = opb_q;
  assign oFP_N     = opn_q;
  assign oBUSY     = iREQ & ~oDONE;

endmodule
